logic_gates: RTL and testbench

//   Bitwise basic-gate block: AND, OR and NOT on two operand buses, plus NAND/NOR/XOR/XNOR.

---
 rtl/logic_gates.sv | 80 ++++++++
 tb/tb_logic_gates.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/logic_gates.sv
// rtl/logic_gates.sv - bitwise AND/OR/NOT/NAND/NOR/XOR/XNOR with optional output register
// REG_OUT=1 registers every result with async reset to zero; REG_OUT=0 is purely combinational.
module logic_gates #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oAnd,
  output logic [WIDTH-1:0] oOr,
  output logic [WIDTH-1:0] oNot,
  output logic [WIDTH-1:0] oNand,
  output logic [WIDTH-1:0] oNor,
  output logic [WIDTH-1:0] oXor,
  output logic [WIDTH-1:0] oXnor
);

  logic [WIDTH-1:0] and_d, or_d, not_d, nand_d, nor_d, xor_d, xnor_d;

  assign and_d  = iA & iB;
  assign or_d   = iA | iB;
  assign not_d  = ~iA;
  assign nand_d = ~(iA & iB);
  assign nor_d  = ~(iA | iB);
  assign xor_d  = iA ^ iB;
  assign xnor_d = ~(iA ^ iB);

  generate
    if (WIDTH < 1) begin : g_width_check
      $error("logic_gates: WIDTH must be >= 1");
    end

    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] and_q, or_q, not_q, nand_q, nor_q, xor_q, xnor_q;

      // Reset clears the inverting outputs too, so all results read zero during reset.
      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          and_q  <= '0;
          or_q   <= '0;
          not_q  <= '0;
          nand_q <= '0;
          nor_q  <= '0;
          xor_q  <= '0;
          xnor_q <= '0;
        end else begin
          and_q  <= and_d;
          or_q   <= or_d;
          not_q  <= not_d;
          nand_q <= nand_d;
          nor_q  <= nor_d;
          xor_q  <= xor_d;
          xnor_q <= xnor_d;
        end
      end

      assign oAnd  = and_q;
      assign oOr   = or_q;
      assign oNot  = not_q;
      assign oNand = nand_q;
      assign oNor  = nor_q;
      assign oXor  = xor_q;
      assign oXnor = xnor_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = iClk ^ iRst;

      assign oAnd  = and_d;
      assign oOr   = or_d;
      assign oNot  = not_d;
      assign oNand = nand_d;
      assign oNor  = nor_d;
      assign oXor  = xor_d;
      assign oXnor = xnor_d;
    end
  endgenerate

endmodule

// File: tb/tb_logic_gates.sv
// tb/tb_logic_gates.sv - self-checking bench for logic_gates
// Three instances: 1-bit registered, 8-bit registered, 1-bit combinational.
module tb_logic_gates;

  logic clk;
  logic rst1, rst8, rstc;
  logic a1, b1, ac, bc;
  logic [7:0] a8, b8;
  logic o1_and, o1_or, o1_not, o1_nand, o1_nor, o1_xor, o1_xnor;
  logic oc_and, oc_or, oc_not, oc_nand, oc_nor, oc_xor, oc_xnor;
  logic [7:0] o8_and, o8_or, o8_not, o8_nand, o8_nor, o8_xor, o8_xnor;

  int n_cmp;
  int n_fail;

  logic_gates #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
    .iClk(clk), .iRst(rst1), .iA(a1), .iB(b1),
    .oAnd(o1_and), .oOr(o1_or), .oNot(o1_not), .oNand(o1_nand),
    .oNor(o1_nor), .oXor(o1_xor), .oXnor(o1_xnor)
  );

  logic_gates #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
    .iClk(clk), .iRst(rst8), .iA(a8), .iB(b8),
    .oAnd(o8_and), .oOr(o8_or), .oNot(o8_not), .oNand(o8_nand),
    .oNor(o8_nor), .oXor(o8_xor), .oXnor(o8_xnor)
  );

  logic_gates #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
    .iClk(clk), .iRst(rstc), .iA(ac), .iB(bc),
    .oAnd(oc_and), .oOr(oc_or), .oNot(oc_not), .oNand(oc_nand),
    .oNor(oc_nor), .oXor(oc_xor), .oXnor(oc_xnor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic [6:0] exp;  // {and, or, not, nand, nor, xor, xnor}
  } vec_t;

  vec_t tt[5];

  // Reference: each output bit from the count of ones among a[i], b[i].
  function automatic logic [6:0][7:0] ref_ops(input logic [7:0] a, input logic [7:0] b);
    logic [6:0][7:0] r;
    int s;
    for (int i = 0; i < 8; i++) begin
      s = int'(a[i]) + int'(b[i]);
      r[0][i] = (s == 2);
      r[1][i] = (s >= 1);
      r[2][i] = (a[i] == 1'b0);
      r[3][i] = (s != 2);
      r[4][i] = (s == 0);
      r[5][i] = (s == 1);
      r[6][i] = (s != 1);
    end
    return r;
  endfunction

  function automatic logic [55:0] flat8(input logic [6:0][7:0] r);
    return {r[0], r[1], r[2], r[3], r[4], r[5], r[6]};
  endfunction

  function automatic logic [6:0] flat1(input logic [6:0][7:0] r);
    return {r[0][0], r[1][0], r[2][0], r[3][0], r[4][0], r[5][0], r[6][0]};
  endfunction

  function automatic logic [6:0] act1();
    return {o1_and, o1_or, o1_not, o1_nand, o1_nor, o1_xor, o1_xnor};
  endfunction

  function automatic logic [6:0] actc();
    return {oc_and, oc_or, oc_not, oc_nand, oc_nor, oc_xor, oc_xnor};
  endfunction

  function automatic logic [55:0] act8();
    return {o8_and, o8_or, o8_not, o8_nand, o8_nor, o8_xor, o8_xnor};
  endfunction

  task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rx, ry;
    n_cmp  = 0;
    n_fail = 0;

    tt[0] = '{1'b0, 1'b0, 7'b0011101};
    tt[1] = '{1'b1, 1'b0, 7'b0101010};
    tt[2] = '{1'b0, 1'b1, 7'b0111010};
    tt[3] = '{1'b1, 1'b1, 7'b1100001};
    tt[4] = '{1'b0, 1'b0, 7'b0011101};

    rst1 = 1'b0; rst8 = 1'b0; rstc = 1'b0;
    a1 = 1'b1; b1 = 1'b1; ac = 1'b0; bc = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF;

    // Asynchronous reset before the first clock edge
    #1 rst1 = 1'b1; rst8 = 1'b1;
    #1;
    check("reset_async_w1", {49'b0, act1()}, 56'b0);
    check("reset_async_w8", act8(), 56'b0);

    @(negedge clk);
    rst1 = 1'b0; rst8 = 1'b0;

    // Truth table, one vector per cycle, checked one edge later
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a1 = tt[i].a; b1 = tt[i].b;
      @(posedge clk); #1;
      check($sformatf("truth_table[%0d]", i), {49'b0, act1()}, {49'b0, tt[i].exp});
    end

    // Mid-cycle input change must wait for the next edge
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    check("latency_and_before", {55'b0, o1_and}, 56'd0);
    #2 a1 = 1'b1;
    #1;
    check("latency_and_midcycle", {55'b0, o1_and}, 56'd0);
    @(posedge clk); #1;
    check("latency_and_after", {55'b0, o1_and}, 56'd1);

    // Reset pulse mid-operation
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check("midrst_loaded", {49'b0, act1()}, {49'b0, flat1(ref_ops(8'h01, 8'h00))});
    #2 rst1 = 1'b1;
    #1;
    check("midrst_async_zero", {49'b0, act1()}, 56'b0);
    @(posedge clk); #1;
    check("midrst_hold_zero", {49'b0, act1()}, 56'b0);
    #1 rst1 = 1'b0;
    #1;
    check("midrst_released_zero", {49'b0, act1()}, 56'b0);
    @(posedge clk); #1;
    check("midrst_reload", {49'b0, act1()}, {49'b0, flat1(ref_ops(8'h01, 8'h00))});

    // 8-bit directed vector
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h3C;
    @(posedge clk); #1;
    check("width8_directed", act8(), {8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33});

    // 8-bit randomized, with occasional mid-cycle re-drive before the edge
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom);
      a8 = ra; b8 = rb;
      if ($urandom_range(0, 3) == 0) begin
        #2;
        ra = 8'($urandom);
        a8 = ra;
      end
      @(posedge clk); #1;
      check($sformatf("rand_w8[%0d]", i), act8(), flat8(ref_ops(ra, rb)));
    end

    // Combinational instance: zero latency, reset ignored
    for (int i = 0; i < 4; i++) begin
      ac = tt[i].a; bc = tt[i].b; rstc = i[0];
      #1;
      check($sformatf("comb_table[%0d]", i), {49'b0, actc()}, {49'b0, tt[i].exp});
      #39;
    end
    rstc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx = 1'($urandom); ry = 1'($urandom);
      ac = rx; bc = ry;
      #1;
      check($sformatf("rand_comb[%0d]", i), {49'b0, actc()},
            {49'b0, flat1(ref_ops({7'b0, rx}, {7'b0, ry}))});
      #3;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
